// File: rtl/operand_fetch_if.sv
// ============================================================================
// Module   : operand_fetch_if
// Brief    : Bus/handshake bundle between the operand fetcher and its users.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface operand_fetch_if;
   logic       RDY;
   logic       start;
   logic       abort;
   logic [1:0] RWDTH;
   logic [7:0] DI;
   logic [7:0] DR;
   logic [7:0] D3;
   logic [7:0] D4;
   logic [1:0] byte_idx;
   logic       busy;
   logic       valid;

   modport master (
      output RDY, start, abort, RWDTH, DI,
      input  DR, D3, D4, byte_idx, busy, valid
   );

   modport slave (
      input  RDY, start, abort, RWDTH, DI,
      output DR, D3, D4, byte_idx, busy, valid
   );
endinterface

`default_nettype wire

// File: rtl/operand_fetch.sv
// ============================================================================
// Module   : operand_fetch
// Brief    : Assembles a 1/2/3-byte little-endian operand into DR/D3/D4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_fetch #(
   parameter int ZERO_FILL = 1
) (
   input  wire logic     clk,
   input  wire logic     reset,
   operand_fetch_if.slave bus
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   localparam logic [1:0] c_r08 = 2'b00;
   localparam logic [1:0] c_r16 = 2'b01;
   localparam logic [1:0] c_r24 = 2'b10;

   logic [1:0] r_state;
   logic [1:0] w_next_state;
   logic [1:0] r_width;
   logic [1:0] r_idx;
   logic [7:0] r_dr;
   logic [7:0] r_d3;
   logic [7:0] r_d4;
   logic       w_busy;
   logic       w_valid;
   logic       w_launch;
   logic       w_capture;
   logic       w_last;
   logic [1:0] w_width_norm;

   assign w_launch     = ((r_state == S_IDLE) || (r_state == S_DONE)) && bus.start;
   assign w_capture    = (r_state == S_FETCH) && bus.RDY;
   // Width encoding doubles as the index of the final byte (0, 1 or 2).
   assign w_last       = (r_idx == r_width);
   assign w_width_norm = (bus.RWDTH == 2'b11) ? c_r08 : bus.RWDTH;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      if (bus.abort) begin
         w_next_state = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (bus.start) w_next_state = S_FETCH;
            S_FETCH: if (bus.RDY && w_last) w_next_state = S_DONE;
            S_DONE:  w_next_state = bus.start ? S_FETCH : S_IDLE;
            default: w_next_state = S_IDLE;
         endcase
      end
   end

   always_comb begin
      w_busy  = 1'b0;
      w_valid = 1'b0;
      case (r_state)
         S_FETCH: w_busy  = 1'b1;
         S_DONE:  w_valid = 1'b1;
         default: ;
      endcase
   end

   // Abort wins over both launch and capture: the in-flight byte is dropped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_width <= c_r08;
         r_idx   <= 2'd0;
         r_dr    <= 8'h00;
         r_d3    <= 8'h00;
         r_d4    <= 8'h00;
      end else if (bus.abort) begin
         r_idx <= 2'd0;
      end else if (w_launch) begin
         r_width <= w_width_norm;
         r_idx   <= 2'd0;
         if (ZERO_FILL != 0) begin
            r_dr <= 8'h00;
            r_d3 <= 8'h00;
            r_d4 <= 8'h00;
         end
      end else if (w_capture) begin
         case (r_width)
            c_r24: begin
               case (r_idx)
                  2'd0:    r_d4 <= bus.DI;
                  2'd1:    r_d3 <= bus.DI;
                  default: r_dr <= bus.DI;
               endcase
            end
            c_r16: begin
               if (r_idx == 2'd0) r_d3 <= bus.DI;
               else               r_dr <= bus.DI;
            end
            default: r_dr <= bus.DI;
         endcase
         r_idx <= w_last ? 2'd0 : r_idx + 2'd1;
      end
   end

   assign bus.DR       = r_dr;
   assign bus.D3       = r_d3;
   assign bus.D4       = r_d4;
   assign bus.byte_idx = r_idx;
   assign bus.busy     = w_busy;
   assign bus.valid    = w_valid;

endmodule

`default_nettype wire

// File: tb/tb_operand_fetch.sv
// ============================================================================
// Module   : tb_operand_fetch
// Brief    : Directed vector bench for operand_fetch (both ZERO_FILL settings).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_operand_fetch;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   operand_fetch_if bus1 ();
   operand_fetch_if bus0 ();

   // Both instances see identical stimulus; only bus1 is driven directly.
   assign bus0.RDY   = bus1.RDY;
   assign bus0.start = bus1.start;
   assign bus0.abort = bus1.abort;
   assign bus0.RWDTH = bus1.RWDTH;
   assign bus0.DI    = bus1.DI;

   operand_fetch #(.ZERO_FILL(1)) dut_zf1 (.clk(clk), .reset(reset), .bus(bus1));
   operand_fetch #(.ZERO_FILL(0)) dut_zf0 (.clk(clk), .reset(reset), .bus(bus0));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rdy;
      logic       start;
      logic       abort;
      logic [1:0] rwdth;
      logic [7:0] di;
      logic [7:0] dr;
      logic [7:0] d3;
      logic [7:0] d4;
      logic [1:0] idx;
      logic       busy;
      logic       valid;
   } vec_t;

   localparam int NV = 20;
   vec_t vecs [NV];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   task automatic step(input logic rdy, input logic st, input logic ab,
                       input logic [1:0] w, input logic [7:0] di);
      bus1.RDY   = rdy;
      bus1.start = st;
      bus1.abort = ab;
      bus1.RWDTH = w;
      bus1.DI    = di;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all1(input string tag, input logic [7:0] dr, input logic [7:0] d3,
                           input logic [7:0] d4, input logic [1:0] idx,
                           input logic busy, input logic valid);
      chk({tag, " DR"},    bus1.DR, dr);
      chk({tag, " D3"},    bus1.D3, d3);
      chk({tag, " D4"},    bus1.D4, d4);
      chk({tag, " idx"},   {6'd0, bus1.byte_idx}, {6'd0, idx});
      chk({tag, " busy"},  {7'd0, bus1.busy},  {7'd0, busy});
      chk({tag, " valid"}, {7'd0, bus1.valid}, {7'd0, valid});
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      bus1.RDY = 1'b0; bus1.start = 1'b0; bus1.abort = 1'b0;
      bus1.RWDTH = 2'b00; bus1.DI = 8'h00;

      //            rdy   st    ab    w      di      DR     D3     D4     idx   busy  valid
      // 24b, no stalls: DI 34,12,AB
      vecs[0]  = '{1'b0, 1'b1, 1'b0, 2'b10, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 1'b1, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 2'b00, 8'h34, 8'h00, 8'h00, 8'h34, 2'd1, 1'b1, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 2'b00, 8'h12, 8'h00, 8'h12, 8'h34, 2'd2, 1'b1, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 2'b00, 8'hAB, 8'hAB, 8'h12, 8'h34, 2'd0, 1'b0, 1'b1};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 8'hAB, 8'h12, 8'h34, 2'd0, 1'b0, 1'b0};
      // 16b with two stall cycles between bytes
      vecs[5]  = '{1'b0, 1'b1, 1'b0, 2'b01, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 1'b1, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 1'b0, 2'b00, 8'hCD, 8'h00, 8'hCD, 8'h00, 2'd1, 1'b1, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 2'b00, 8'h99, 8'h00, 8'hCD, 8'h00, 2'd1, 1'b1, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 2'b00, 8'h77, 8'h00, 8'hCD, 8'h00, 2'd1, 1'b1, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 1'b0, 2'b00, 8'hEF, 8'hEF, 8'hCD, 8'h00, 2'd0, 1'b0, 1'b1};
      // start in DONE restarts as 8b; start in FETCH (with RWDTH=10) ignored
      vecs[10] = '{1'b0, 1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 1'b1, 1'b0};
      vecs[11] = '{1'b1, 1'b1, 1'b0, 2'b10, 8'h5A, 8'h5A, 8'h00, 8'h00, 2'd0, 1'b0, 1'b1};
      vecs[12] = '{1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 8'h5A, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0};
      // abort on the edge that would capture byte 1 of a 24b fetch
      vecs[13] = '{1'b0, 1'b1, 1'b0, 2'b10, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 1'b1, 1'b0};
      vecs[14] = '{1'b1, 1'b0, 1'b0, 2'b00, 8'h11, 8'h00, 8'h00, 8'h11, 2'd1, 1'b1, 1'b0};
      vecs[15] = '{1'b1, 1'b1, 1'b1, 2'b00, 8'h22, 8'h00, 8'h00, 8'h11, 2'd0, 1'b0, 1'b0};
      vecs[16] = '{1'b1, 1'b0, 1'b0, 2'b00, 8'h33, 8'h00, 8'h00, 8'h11, 2'd0, 1'b0, 1'b0};
      // RWDTH=11 behaves as 8b; abort+start in DONE returns to IDLE
      vecs[17] = '{1'b0, 1'b1, 1'b0, 2'b11, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 1'b1, 1'b0};
      vecs[18] = '{1'b1, 1'b0, 1'b0, 2'b00, 8'hC3, 8'hC3, 8'h00, 8'h00, 2'd0, 1'b0, 1'b1};
      vecs[19] = '{1'b0, 1'b1, 1'b1, 2'b10, 8'h00, 8'hC3, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0};

      @(posedge clk);
      #1;
      chk_all1("reset", 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0);
      reset = 1'b0;
      step(1'b0, 1'b0, 1'b0, 2'b00, 8'h00);
      chk_all1("idle", 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0);

      for (int i = 0; i < NV; i++) begin
         step(vecs[i].rdy, vecs[i].start, vecs[i].abort, vecs[i].rwdth, vecs[i].di);
         chk_all1($sformatf("v%0d", i), vecs[i].dr, vecs[i].d3, vecs[i].d4,
                  vecs[i].idx, vecs[i].busy, vecs[i].valid);
      end

      // 24b of FF then 8b of 5A: zero-fill clears D3/D4, non-fill keeps FF
      step(1'b0, 1'b1, 1'b0, 2'b10, 8'h00);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 2'b00, 8'hFF);
      chk_all1("ff24", 8'hFF, 8'hFF, 8'hFF, 2'd0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 2'b00, 8'h00);
      step(1'b0, 1'b1, 1'b0, 2'b00, 8'h00);
      chk("zf0 hold D3", bus0.D3, 8'hFF);
      step(1'b1, 1'b0, 1'b0, 2'b00, 8'h5A);
      chk_all1("zf1 8b", 8'h5A, 8'h00, 8'h00, 2'd0, 1'b0, 1'b1);
      chk("zf0 DR", bus0.DR, 8'h5A);
      chk("zf0 D3", bus0.D3, 8'hFF);
      chk("zf0 D4", bus0.D4, 8'hFF);
      chk("zf0 valid", {7'd0, bus0.valid}, 8'h01);

      // Asynchronous reset in the middle of a 24b fetch
      step(1'b0, 1'b0, 1'b0, 2'b00, 8'h00);
      step(1'b0, 1'b1, 1'b0, 2'b10, 8'h00);
      step(1'b1, 1'b0, 1'b0, 2'b00, 8'h77);
      chk_all1("pre-rst", 8'h00, 8'h00, 8'h77, 2'd1, 1'b1, 1'b0);
      #3 reset = 1'b1;
      #1;
      chk_all1("async rst", 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0);
      chk("async rst zf0 D4", bus0.D4, 8'h00);
      @(posedge clk);
      #1 reset = 1'b0;
      step(1'b1, 1'b0, 1'b0, 2'b00, 8'h55);
      chk_all1("post-rst", 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
